display_sum: RTL and testbench

DISPLAY_SUM -- requirements
Module: display_sum

---
 rtl/display_pkg.sv | 28 ++
 rtl/bcd7seg.sv | 28 ++
 rtl/display_sum.sv | 139 +++++++++++++
 tb/tb_display_sum.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display_sum block: FSM state type,
// active-low abcdefg glyphs, blank pattern and refresh defaults.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int REFRESH_DIV_DEFAULT = 50000;

  // Double-dabble needs one iteration per input bit ({co,zi} is 5 bits).
  localparam int CONV_ITERS = 5;

  localparam logic [6:0] GLYPH_0     = 7'b0000001;
  localparam logic [6:0] GLYPH_1     = 7'b1001111;
  localparam logic [6:0] GLYPH_2     = 7'b0010010;
  localparam logic [6:0] GLYPH_3     = 7'b0000110;
  localparam logic [6:0] GLYPH_4     = 7'b1001100;
  localparam logic [6:0] GLYPH_5     = 7'b0100100;
  localparam logic [6:0] GLYPH_6     = 7'b0100000;
  localparam logic [6:0] GLYPH_7     = 7'b0001111;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0000100;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD digit to active-low abcdefg glyph decoder.
// Codes 10..15 decode to the blank pattern.
module bcd7seg
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for one digit.
  always_comb begin
    seg_o = GLYPH_BLANK;
    case (digit_i)
      4'd0:    seg_o = GLYPH_0;
      4'd1:    seg_o = GLYPH_1;
      4'd2:    seg_o = GLYPH_2;
      4'd3:    seg_o = GLYPH_3;
      4'd4:    seg_o = GLYPH_4;
      4'd5:    seg_o = GLYPH_5;
      4'd6:    seg_o = GLYPH_6;
      4'd7:    seg_o = GLYPH_7;
      4'd8:    seg_o = GLYPH_8;
      4'd9:    seg_o = GLYPH_9;
      default: seg_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/display_sum.sv
// display_sum: captures a 5-bit adder result {co,zi}, converts it to two BCD
// digits with a serial double-dabble FSM (IDLE -> CONV x5 -> DONE), and
// multiplexes tens/units onto a 4-digit active-low 7-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks the tens digit when 0.
//
// Handshake: load is a request sampled on the rising edge only while busy=0;
// busy=1 from the capture edge until the display registers are written, and
// any load seen while busy=1 is dropped (no queuing).
module display_sum
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       co,
  input  logic [3:0] zi,
  input  logic       load,
  output logic       busy,
  output logic [6:0] sseg,
  output logic [3:0] an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_t         state_q, state_d;
  logic [4:0]     value_q, value_d;
  logic [7:0]     bcd_q, bcd_d;
  logic [2:0]     iter_q, iter_d;
  logic [3:0]     tens_q, tens_d;
  logic [3:0]     units_q, units_d;
  logic [CW-1:0]  refresh_q, refresh_d;
  logic           sel_q, sel_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     sseg_q, sseg_d;

  logic [7:0]     adj;
  logic [12:0]    shifted;
  logic [3:0]     digit;
  logic [6:0]     glyph;

  // Conversion FSM: next state, scratch datapath and display-register update.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    tens_d  = tens_q;
    units_d = units_q;
    adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    shifted  = {adj, value_q} << 1;
    case (state_q)
      IDLE: begin
        if (load) begin
          value_d = {co, zi};
          bcd_d   = 8'd0;
          iter_d  = 3'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = shifted[12:5];
        value_d = shifted[4:0];
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'(CONV_ITERS - 1)) state_d = DONE;
      end
      DONE: begin
        // Display registers change only here, so the scan never sees
        // partially converted digits.
        tens_d  = bcd_q[7:4];
        units_d = bcd_q[3:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Refresh counter and digit-select toggle, independent of the FSM.
  always_comb begin
    refresh_d = refresh_q + CW'(1);
    sel_d     = sel_q;
    if (refresh_q == CW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      sel_d     = ~sel_q;
    end
  end

  assign digit = sel_q ? tens_q : units_q;

  bcd7seg u_bcd7seg (
    .digit_i (digit),
    .seg_o   (glyph)
  );

  // Anode/segment next values from the current digit select.
  always_comb begin
    an_d   = sel_q ? 4'b1101 : 4'b1110;
    sseg_d = glyph;
`ifdef LEADING_ZERO_BLANK_EN
    if (sel_q && (tens_q == 4'd0)) begin
      an_d   = 4'b1111;
      sseg_d = GLYPH_BLANK;
    end
`endif
  end

  // State, scratch, display, scan and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      value_q   <= 5'd0;
      bcd_q     <= 8'd0;
      iter_q    <= 3'd0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      refresh_q <= '0;
      sel_q     <= 1'b0;
      an_q      <= 4'b1111;
      sseg_q    <= GLYPH_BLANK;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
      an_q      <= an_d;
      sseg_q    <= sseg_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_display_sum.sv
// Testbench for display_sum with REFRESH_DIV=4. Honours LEADING_ZERO_BLANK_EN.
module tb_display_sum;

  logic       clk;
  logic       rst;
  logic       co;
  logic [3:0] zi;
  logic       load;
  logic       busy;
  logic [6:0] sseg;
  logic [3:0] an;

  int n_checks;
  int n_errors;
  int shown_v;
  int exp_q[$];
  logic [6:0] glyph_tab[10];

  display_sum #(.REFRESH_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .co   (co),
    .zi   (zi),
    .load (load),
    .busy (busy),
    .sseg (sseg),
    .an   (an)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected anode/segments for a value in the given scan slot.
  function automatic void exp_slot(input int v, input logic tens_slot,
                                   output logic [3:0] ean, output logic [6:0] eseg);
    if (!tens_slot) begin
      ean  = 4'b1110;
      eseg = glyph_tab[v % 10];
    end else begin
      ean  = 4'b1101;
      eseg = glyph_tab[v / 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (v / 10 == 0) begin
        ean  = 4'b1111;
        eseg = 7'b1111111;
      end
`endif
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; co = 1'b0; zi = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (an !== 4'b1111 || sseg !== 7'b1111111 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: an=%b sseg=%b busy=%b, want an=1111 sseg=1111111 busy=0", an, sseg, busy);
    end
    shown_v = 0;
  endtask

  // Release reset and check the scan: 4 edges per slot, units first.
  task automatic test_scan();
    logic [3:0] ean;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      ean = (((k - 1) / 4) % 2 == 1) ? 4'b1101 : 4'b1110;
      n_checks++;
      if (an !== ean || (k == 1 && sseg !== 7'b0000001)) begin
        n_errors++;
        $display("FAIL scan_k%0d: an=%b sseg=%b, want an=%b", k, an, sseg, ean);
      end
    end
  endtask

  // Load v, optionally pulse a spurious load ign_at edges later, check busy
  // timing, display hold during conversion, then the new display contents.
  task automatic run_conversion(input int v, input int ign_at, input int ign_v, input string name);
    logic [3:0] ean;
    logic [6:0] eseg;
    int cyc;
    int dv;
    bit seen_u, seen_t;
    co = v[4]; zi = v[3:0]; load = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    load = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_busy_start: busy=%b, want 1", name, busy);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      exp_slot(shown_v, an !== 4'b1110, ean, eseg);
      n_checks++;
      if (an !== ean || sseg !== eseg) begin
        n_errors++;
        $display("FAIL %s_hold_c%0d: an=%b sseg=%b, want an=%b sseg=%b", name, cyc, an, sseg, ean, eseg);
      end
      if (cyc + 1 == ign_at) begin
        co = ign_v[4]; zi = ign_v[3:0]; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(posedge clk); #1;
      load = 1'b0;
      cyc++;
    end
    n_checks++;
    if (cyc !== 6) begin
      n_errors++;
      $display("FAIL %s_latency: busy edges=%0d, want 6", name, cyc);
    end
    dv = exp_q.pop_front();
    @(posedge clk); #1;
    seen_u = 0; seen_t = 0;
    for (int i = 0; i < 10; i++) begin
      exp_slot(dv, an !== 4'b1110, ean, eseg);
      if (an === 4'b1110) seen_u = 1; else seen_t = 1;
      n_checks++;
      if (an !== ean || sseg !== eseg) begin
        n_errors++;
        $display("FAIL %s_show_v%0d: an=%b sseg=%b, want an=%b sseg=%b", name, dv, an, sseg, ean, eseg);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!(seen_u && seen_t)) begin
      n_errors++;
      $display("FAIL %s_slots: units_seen=%0d tens_seen=%0d, want 1 1", name, seen_u, seen_t);
    end
    shown_v = dv;
  endtask

  task automatic test_directed();
    run_conversion(16, -1, 0, "sixteen");
    run_conversion(30, -1, 0, "thirty");
    run_conversion(5,  -1, 0, "five");
    run_conversion(0,  -1, 0, "zero");
    run_conversion(31, -1, 0, "max");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      run_conversion($urandom_range(0, 31), -1, 0, "rand");
    end
  endtask

  task automatic test_ignore_busy();
    run_conversion(16, 2, 31, "ignore");
    run_conversion(31, -1, 0, "after_ignore");
    run_conversion(7, 5, 22, "ignore_late");
  endtask

  // Reset during conversion: blank while held, then 0 and never the partial value.
  task automatic test_reset_mid();
    logic [3:0] ean;
    logic [6:0] eseg;
    co = 1'b1; zi = 4'hF; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (an !== 4'b1111 || sseg !== 7'b1111111 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_hold: an=%b sseg=%b busy=%b, want 1111 1111111 0", an, sseg, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (an !== 4'b1111 || sseg !== 7'b1111111) begin
      n_errors++;
      $display("FAIL midreset_hold2: an=%b sseg=%b, want 1111 1111111", an, sseg);
    end
    @(negedge clk);
    rst = 1'b0;
    shown_v = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      exp_slot(0, an !== 4'b1110, ean, eseg);
      n_checks++;
      if (an !== ean || sseg !== eseg || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_after: an=%b sseg=%b busy=%b, want an=%b sseg=%b busy=0", an, sseg, busy, ean, eseg);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    glyph_tab[0] = 7'b0000001; glyph_tab[1] = 7'b1001111;
    glyph_tab[2] = 7'b0010010; glyph_tab[3] = 7'b0000110;
    glyph_tab[4] = 7'b1001100; glyph_tab[5] = 7'b0100100;
    glyph_tab[6] = 7'b0100000; glyph_tab[7] = 7'b0001111;
    glyph_tab[8] = 7'b0000000; glyph_tab[9] = 7'b0000100;
    test_reset();
    test_scan();
    test_directed();
    test_random();
    test_ignore_busy();
    test_reset_mid();
    run_conversion(23, -1, 0, "post_reset");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
